mips_multicycle_control: RTL and testbench
==========================================

Name: mips_multicycle_control

Overview:
- Moore FSM control unit for the multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Produces every datapath enable and mux select, including the 3-bit alucontrol code the ALU consumes; consumes the ALU zero flag for branches.
- Sits between the instruction register (op/funct fields) and the datapath.

Parameters:
- TRAP_ON_ILLEGAL, 0, 1 = an illegal opcode parks the FSM in HALT until reset; 0 = it returns to FETCH.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- op  input  6  instruction[31:26] from the instruction register
- funct  input  6  instruction[5:0]
- zero  input  1  ALU zero flag, same cycle
- alucontrol  output  3  000 and, 001 or, 010 add, 110 sub, 111 slt
- alusrca  output  1  0 = PC, 1 = register A
- alusrcb  output  2  00 = B, 01 = const 4, 10 = signimm, 11 = signimm<<2
- pcsrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- pcen  output  1  PC write enable
- iord  output  1  memory address select, 1 = ALUOut
- memwrite, irwrite, regwrite  output  1 each  write enables
- regdst, memtoreg  output  1 each  register-file mux selects
- instr_done  output  1  one-cycle pulse in the final state of each instruction
- illegal  output  1  one-cycle pulse in DECODE on an unsupported opcode

Behaviour:
- Clocking and reset:
  - Single clock; reset is synchronous and active-high.
  - Reset forces state = FETCH on the next edge, including mid-instruction; the partial instruction is abandoned.
  - While reset is high, irwrite, pcen, regwrite, memwrite, instr_done and illegal are forced 0.
  - Other outputs show FETCH values.
- States:
  - FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX, HALT.
- Transitions:
  - FETCH -> DECODE.
  - DECODE by op:
    - 100011/101011 -> MEMADR
    - 000000 -> RTYPEEX
    - 000100 -> BEQEX
    - 001000 -> ADDIEX
    - 000010 -> JEX
    - else -> HALT if TRAP_ON_ILLEGAL, else FETCH
  - MEMADR -> MEMRD (lw) or MEMWR (sw).
  - MEMRD -> MEMWB.
  - RTYPEEX -> RTYPEWB.
  - ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX, JEX -> FETCH.
  - HALT -> HALT.
- Outputs per state (all unlisted outputs are 0):
  - FETCH: alusrcb=01, aluop=add, irwrite=1, pcwrite=1.
  - DECODE: alusrcb=11, aluop=add.
  - MEMADR: alusrca=1, alusrcb=10, aluop=add.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - RTYPEEX: alusrca=1, aluop=funct.
  - RTYPEWB: regdst=1, regwrite=1.
  - BEQEX: alusrca=1, aluop=sub, pcsrc=01, branch=1.
  - ADDIEX: alusrca=1, alusrcb=10, aluop=add.
  - ADDIWB: regwrite=1.
  - JEX: pcsrc=10, pcwrite=1.
  - HALT: all 0.
- pcen = pcwrite | (branch & zero). Combinational in zero, no added latency.
- instr_done is high in MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX and JEX.
- Latency in cycles, FETCH through done inclusive: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- alucontrol mapping:
  - aluop add -> 010; aluop sub -> 110.
  - aluop funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - Any other funct -> 011 (ALU yields 0); no illegal pulse, writeback still occurs.

Optional Feature:
- Macro MIPS_CTRL_BNE_EN.
- When defined: op 000101 goes DECODE -> BNEEX. BNEEX drives the same outputs as BEQEX, but pcen = pcwrite | (branch_ne & ~zero). Latency 3 cycles; instr_done pulses in BNEEX.
- When undefined: op 000101 is illegal and follows the TRAP_ON_ILLEGAL rule.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode and funct localparams
  - state_t enum
  - aluop_t enum (add, sub, funct)
  - alucontrol codes
- Sub-module mips_alu_decoder: combinational aluop + funct -> alucontrol.
- FSM, output decode and pcen logic stay in the top module.

Test Plan:
- Reset held 3 cycles, then op=100011 (lw): states FETCH, DECODE, MEMADR, MEMRD, MEMWB. Exactly one irwrite cycle; regwrite=1 with memtoreg=1 in cycle 5; instr_done in cycle 5.
- R-type with funct=101010: alucontrol=111 in RTYPEEX; regdst=1 and regwrite=1 in RTYPEWB. Repeat with funct=100010 -> 110.
- beq with zero=1 in BEQEX: pcen=1, pcsrc=01. Same with zero=0: pcen=0. Next state FETCH in both cases.
- op=111111, TRAP_ON_ILLEGAL=0: illegal pulses once in DECODE, then FETCH. With TRAP_ON_ILLEGAL=1: stuck in HALT, all enables 0, released only by reset.
- Reset asserted during MEMWR: memwrite=0 in that cycle; FETCH on the next edge.
- With MIPS_CTRL_BNE_EN, op=000101: zero=0 gives pcen=1, zero=1 gives pcen=0. Without the macro: illegal pulse.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, funct codes,
// FSM states, ALU operation classes and the alucontrol codes the ALU consumes.
package mips_ctrl_pkg;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [5:0] FunctAdd = 6'b100000;
  localparam logic [5:0] FunctSub = 6'b100010;
  localparam logic [5:0] FunctAnd = 6'b100100;
  localparam logic [5:0] FunctOr  = 6'b100101;
  localparam logic [5:0] FunctSlt = 6'b101010;

  localparam logic [2:0] AluAnd  = 3'b000;
  localparam logic [2:0] AluOr   = 3'b001;
  localparam logic [2:0] AluAdd  = 3'b010;
  localparam logic [2:0] AluNone = 3'b011;
  localparam logic [2:0] AluSub  = 3'b110;
  localparam logic [2:0] AluSlt  = 3'b111;

  // Add is encoded as zero so states that do not name an ALU operation default to it.
  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10
  } aluop_t;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StRtypeEx,
    StRtypeWb,
    StBeqEx,
    StAddiEx,
    StAddiWb,
    StJEx,
    StHalt,
    StBneEx
  } state_t;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU decoder: maps the FSM's ALU operation class and the
// instruction funct field onto the 3-bit alucontrol code.
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = AluNone;
    case (aluop)
      AluOpAdd: alucontrol = AluAdd;
      AluOpSub: alucontrol = AluSub;
      AluOpFunct: begin
        case (funct)
          FunctAdd: alucontrol = AluAdd;
          FunctSub: alucontrol = AluSub;
          FunctAnd: alucontrol = AluAnd;
          FunctOr:  alucontrol = AluOr;
          FunctSlt: alucontrol = AluSlt;
          // Unsupported funct yields a zero result; writeback still happens.
          default:  alucontrol = AluNone;
        endcase
      end
      default: alucontrol = AluNone;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Moore FSM control unit for the multicycle MIPS datapath.
// Define MIPS_CTRL_BNE_EN to add bne support (op 000101 -> BNEEX).
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned TRAP_ON_ILLEGAL = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alucontrol,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       instr_done,
  output logic       illegal
);

  state_t state_q, state_d, ost;
  aluop_t aluop;
  logic   op_legal;
  logic   pcwrite;
  logic   branch;
`ifdef MIPS_CTRL_BNE_EN
  logic   branch_ne;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    op_legal = 1'b0;
    case (op)
      OpLw, OpSw, OpRtype, OpBeq, OpAddi, OpJ: op_legal = 1'b1;
`ifdef MIPS_CTRL_BNE_EN
      OpBne: op_legal = 1'b1;
`endif
      default: op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        if (!op_legal) begin
          state_d = (TRAP_ON_ILLEGAL != 0) ? StHalt : StFetch;
        end else begin
          case (op)
            OpLw, OpSw: state_d = StMemAdr;
            OpRtype:    state_d = StRtypeEx;
            OpBeq:      state_d = StBeqEx;
            OpAddi:     state_d = StAddiEx;
            OpJ:        state_d = StJEx;
`ifdef MIPS_CTRL_BNE_EN
            OpBne:      state_d = StBneEx;
`endif
            default:    state_d = StFetch;
          endcase
        end
      end
      StMemAdr:  state_d = (op == OpLw) ? StMemRd : StMemWr;
      StMemRd:   state_d = StMemWb;
      StRtypeEx: state_d = StRtypeWb;
      StAddiEx:  state_d = StAddiWb;
      StHalt:    state_d = StHalt;
      default:   state_d = StFetch;
    endcase
  end

  always_comb begin
    // Outputs during reset decode as FETCH, with the write enables masked below.
    ost        = reset ? StFetch : state_q;
    aluop      = AluOpAdd;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
`ifdef MIPS_CTRL_BNE_EN
    branch_ne  = 1'b0;
`endif
    unique case (ost)
      StFetch: begin
        alusrcb = 2'b01;
        irwrite = 1'b1;
        pcwrite = 1'b1;
      end
      StDecode: begin
        alusrcb = 2'b11;
        illegal = ~op_legal;
      end
      StMemAdr, StAddiEx: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      StMemRd: iord = 1'b1;
      StMemWb: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      StMemWr: begin
        iord       = 1'b1;
        memwrite   = 1'b1;
        instr_done = 1'b1;
      end
      StRtypeEx: begin
        alusrca = 1'b1;
        aluop   = AluOpFunct;
      end
      StRtypeWb: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      StBeqEx: begin
        alusrca    = 1'b1;
        aluop      = AluOpSub;
        pcsrc      = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
`ifdef MIPS_CTRL_BNE_EN
      StBneEx: begin
        alusrca    = 1'b1;
        aluop      = AluOpSub;
        pcsrc      = 2'b01;
        branch_ne  = 1'b1;
        instr_done = 1'b1;
      end
`endif
      StAddiWb: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      StJEx: begin
        pcsrc      = 2'b10;
        pcwrite    = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      irwrite    = 1'b0;
      pcwrite    = 1'b0;
      regwrite   = 1'b0;
      memwrite   = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
`ifdef MIPS_CTRL_BNE_EN
    pcen = pcwrite | (branch & zero) | (branch_ne & ~zero);
`else
    pcen = pcwrite | (branch & zero);
`endif
  end

  mips_alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench: two control units (trap off / trap on) run directed and random
// instruction streams against an instruction-level model of the expected control words.
module tb_mips_multicycle_control;

  typedef struct packed {
    logic [2:0] alucontrol;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       instr_done;
    logic       illegal;
  } ctl_t;

  typedef enum int {ClsLw, ClsSw, ClsR, ClsBeq, ClsAddi, ClsJ, ClsBne, ClsIll} cls_t;

  logic       clk = 1'b0;
  logic       reset0, reset1;
  logic [5:0] op, funct;
  logic       zero;
  int         checks = 0;
  int         errors = 0;
  bit         halted1 = 1'b0;

  logic [2:0] alc0, alc1;
  logic [1:0] asb0, asb1, pcs0, pcs1;
  logic       asa0, pce0, iod0, mw0, irw0, rw0, rd0, mtr0, dn0, ill0;
  logic       asa1, pce1, iod1, mw1, irw1, rw1, rd1, mtr1, dn1, ill1;
  ctl_t       obs0, obs1;

  assign obs0 = {alc0, asa0, asb0, pcs0, pce0, iod0, mw0, irw0, rw0, rd0, mtr0, dn0, ill0};
  assign obs1 = {alc1, asa1, asb1, pcs1, pce1, iod1, mw1, irw1, rw1, rd1, mtr1, dn1, ill1};

  always #5 clk = ~clk;

  mips_multicycle_control #(.TRAP_ON_ILLEGAL(0)) dut0 (
    .clk(clk), .reset(reset0), .op(op), .funct(funct), .zero(zero),
    .alucontrol(alc0), .alusrca(asa0), .alusrcb(asb0), .pcsrc(pcs0), .pcen(pce0),
    .iord(iod0), .memwrite(mw0), .irwrite(irw0), .regwrite(rw0), .regdst(rd0),
    .memtoreg(mtr0), .instr_done(dn0), .illegal(ill0)
  );

  mips_multicycle_control #(.TRAP_ON_ILLEGAL(1)) dut1 (
    .clk(clk), .reset(reset1), .op(op), .funct(funct), .zero(zero),
    .alucontrol(alc1), .alusrca(asa1), .alusrcb(asb1), .pcsrc(pcs1), .pcen(pce1),
    .iord(iod1), .memwrite(mw1), .irwrite(irw1), .regwrite(rw1), .regdst(rd1),
    .memtoreg(mtr1), .instr_done(dn1), .illegal(ill1)
  );

  function automatic cls_t classify(input logic [5:0] o);
    case (o)
      6'b100011: return ClsLw;
      6'b101011: return ClsSw;
      6'b000000: return ClsR;
      6'b000100: return ClsBeq;
      6'b001000: return ClsAddi;
      6'b000010: return ClsJ;
`ifdef MIPS_CTRL_BNE_EN
      6'b000101: return ClsBne;
`endif
      default:   return ClsIll;
    endcase
  endfunction

  function automatic int cycles(input cls_t c);
    case (c)
      ClsLw:                   return 5;
      ClsSw, ClsR, ClsAddi:    return 4;
      ClsBeq, ClsJ, ClsBne:    return 3;
      default:                 return 2;
    endcase
  endfunction

  function automatic logic [2:0] alu_of_funct(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b011;
    endcase
  endfunction

  // Control word expected at cycle 'step' of an instruction of class c.
  function automatic ctl_t expect_row(input cls_t c, input int step, input logic [5:0] f,
                                      input logic z);
    ctl_t r;
    r = '0;
    r.alucontrol = 3'b010;
    if (step == 0) begin
      r.alusrcb = 2'b01; r.irwrite = 1'b1; r.pcen = 1'b1;
      return r;
    end
    if (step == 1) begin
      r.alusrcb = 2'b11; r.illegal = (c == ClsIll);
      return r;
    end
    r.instr_done = (step == cycles(c) - 1);
    case (c)
      ClsLw, ClsSw: begin
        if (step == 2) begin r.alusrca = 1'b1; r.alusrcb = 2'b10; end
        else if (step == 3 && c == ClsLw) r.iord = 1'b1;
        else if (step == 3) begin r.iord = 1'b1; r.memwrite = 1'b1; end
        else begin r.memtoreg = 1'b1; r.regwrite = 1'b1; end
      end
      ClsR: begin
        if (step == 2) begin r.alusrca = 1'b1; r.alucontrol = alu_of_funct(f); end
        else begin r.regdst = 1'b1; r.regwrite = 1'b1; end
      end
      ClsAddi: begin
        if (step == 2) begin r.alusrca = 1'b1; r.alusrcb = 2'b10; end
        else r.regwrite = 1'b1;
      end
      ClsBeq, ClsBne: begin
        r.alusrca = 1'b1; r.alucontrol = 3'b110; r.pcsrc = 2'b01;
        r.pcen = (c == ClsBeq) ? z : ~z;
      end
      ClsJ: begin r.pcsrc = 2'b10; r.pcen = 1'b1; end
      default: ;
    endcase
    return r;
  endfunction

  function automatic ctl_t reset_row();
    ctl_t r;
    r = expect_row(ClsLw, 0, 6'd0, 1'b0);
    r.irwrite = 1'b0;
    r.pcen    = 1'b0;
    return r;
  endfunction

  function automatic ctl_t halt_row();
    ctl_t r;
    r = '0;
    r.alucontrol = 3'b010;
    return r;
  endfunction

  task automatic check(input string tag, input ctl_t obs, input ctl_t exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // zmode < 0 randomises zero each cycle; abort_at asserts reset in that step.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int abort_at,
                           input int zmode);
    cls_t c;
    int   n;
    bit   ab, rel1;
    c = classify(o);
    n = cycles(c);
    op = o;
    funct = f;
    for (int s = 0; s < n; s++) begin
      zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      ab   = (s == abort_at);
      rel1 = halted1 && (s == n - 1);
      reset0 = ab;
      reset1 = ab || rel1;
      #4;
      if (ab) check($sformatf("dut0 rst op=%b s=%0d", o, s), obs0, reset_row());
      else check($sformatf("dut0 op=%b f=%b s=%0d", o, f, s), obs0, expect_row(c, s, f, zero));
      if (ab || rel1) check($sformatf("dut1 rst op=%b s=%0d", o, s), obs1, reset_row());
      else if (halted1) check($sformatf("dut1 halt op=%b s=%0d", o, s), obs1, halt_row());
      else check($sformatf("dut1 op=%b f=%b s=%0d", o, f, s), obs1, expect_row(c, s, f, zero));
      @(posedge clk);
      #1;
      if (ab || rel1) halted1 = 1'b0;
      else if (c == ClsIll && s == 1) halted1 = 1'b1;
      if (ab) break;
    end
    reset0 = 1'b0;
    reset1 = 1'b0;
  endtask

  initial begin
    logic [5:0] o, f;
    int         ab;
    reset0 = 1'b1;
    reset1 = 1'b1;
    op = 6'd0;
    funct = 6'd0;
    zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #4;
      check("reset dut0", obs0, reset_row());
      check("reset dut1", obs1, reset_row());
      @(posedge clk);
      #1;
    end
    reset0 = 1'b0;
    reset1 = 1'b0;

    run_instr(6'b100011, 6'b010101, -1, -1);
    run_instr(6'b000000, 6'b101010, -1, -1);
    run_instr(6'b000000, 6'b100010, -1, -1);
    run_instr(6'b000000, 6'b000111, -1, -1);
    run_instr(6'b000100, 6'd0, -1, 1);
    run_instr(6'b000100, 6'd0, -1, 0);
    run_instr(6'b111111, 6'd0, -1, -1);
    run_instr(6'b001000, 6'd0, -1, -1);
    run_instr(6'b000010, 6'd0, -1, -1);
    run_instr(6'b101011, 6'd0, 3, -1);
    run_instr(6'b000101, 6'd0, -1, 0);
    run_instr(6'b000101, 6'd0, -1, 1);
    run_instr(6'b100011, 6'd0, -1, -1);

    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 8))
        0: o = 6'b100011;
        1: o = 6'b101011;
        2: o = 6'b000000;
        3: o = 6'b000100;
        4: o = 6'b001000;
        5: o = 6'b000010;
        6: o = 6'b000101;
        7: o = 6'b000000;
        default: o = 6'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: f = 6'b100000;
        1: f = 6'b100010;
        2: f = 6'b100100;
        3: f = 6'b100101;
        4: f = 6'b101010;
        default: f = 6'($urandom);
      endcase
      ab = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, cycles(classify(o)) - 1)) : -1;
      run_instr(o, f, ab, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
